memory_responder: RTL and testbench
===================================

# memory_responder

Word-organised RAM slave for the multicycle RISC-V core: it serves the control unit's `memory_read` / `memory_write` requests. It accepts a level request, inserts a programmable number of wait states and completes it with a one-cycle `ready` pulse. It serves both instruction fetch and load/store traffic, and gives the stall-capable control FSM a completion handshake.

## Interface
- `ADDR_WIDTH`, default 8: word-index width; depth = 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: wait cycles inserted between acceptance and completion, range 0–15.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `memory_read`  in  1  read request (level).
- `memory_write`  in  1  write request (level).
- `address`  in  32  byte address; word index = `address[ADDR_WIDTH+1:2]`; upper bits ignored.
- `write_data`  in  32  store data.
- `byte_mask`  in  4  write byte enables; bit i enables `write_data[8i+7:8i]`.
- `read_data`  out  32  read result; held between reads.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is being processed.
- `error`  out  1  one-cycle pulse, coincident with `ready`, for a rejected request.

## Operation
FSM states: IDLE, WAIT, RESP.

IDLE
- `busy` = 0.
- If `memory_read` ^ `memory_write`: latch op, word index, `write_data`, `byte_mask` and the reject flag.
  - Reject flag = `address[1:0]` != 0.
  - Load wait counter with LATENCY.
  - Go to WAIT, or to RESP directly if LATENCY = 0.
- If both asserted: latch a rejected request and go as above.
- If neither asserted: stay in IDLE.

WAIT
- `busy` = 1.
- Counter decrements each cycle; leave for RESP on the cycle it reaches 1.
- Net effect: exactly LATENCY cycles are spent in WAIT.
- Request inputs are ignored; latched values are used.

RESP
- `busy` = 1 and `ready` = 1 for one cycle.
- Accepted read: `read_data` is registered from the array at RESP entry, so it is valid during the RESP cycle.
- Accepted write: masked bytes commit to the array on the RESP clock edge.
- Rejected request: `error` = 1; no array access and `read_data` unchanged.
- Always returns to IDLE.

Protocol rules
- The requester must deassert or change its request in the cycle after `ready`.
- A request still held in IDLE is treated as a new request.
- Read-after-write to the same word sees the new data, because the write commits before the next acceptance.
- Address wrap: bits above ADDR_WIDTH+1 are ignored, so address 4·2^ADDR_WIDTH aliases word 0.

Reset (`rst_n` = 0 at a rising edge)
- State returns to IDLE; `ready`, `busy`, `error` go to 0 and `read_data` to 32'h0.
- The wait counter and latched request clear.
- A write pending in WAIT or RESP is aborted and never committed.
- Array contents are not reset.

## Timing
- Request first high in IDLE during cycle t:
  - `busy` = 1 from t+1.
  - `ready` (and `read_data` / `error`) valid in cycle t+1+LATENCY.
  - `busy` falls at t+2+LATENCY.
- Throughput: one access per LATENCY+2 cycles when requests are back-to-back.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Test plan
- LATENCY=2, reset, then write word 32'hDEADBEEF at address 0x10 with mask 4'hF:
  - `ready` appears 3 cycles after the request.
  - Read of 0x10 returns 32'hDEADBEEF on its `ready` cycle with `error` = 0.
- Write 32'h11223344 at address 0x20, then write 32'hAABBCCDD with mask 4'b0101; read back 0x20 → 32'h11BB33DD.
- Read at address 0x13 → `ready` = `error` = 1 in the same cycle, `read_data` unchanged. Read and write asserted together → `error` pulse, and a later read shows no array change.
- LATENCY=0: read → `ready` on the second cycle; back-to-back held read → second `ready` 2 cycles later.
- With ADDR_WIDTH=8: write 32'h5 at address 0x400, read address 0x0 → 32'h5 (wrap).
- Assert `rst_n` = 0 while in WAIT of a write of 32'hFFFFFFFF to 0x30, then release reset:
  - `busy`, `ready`, `error` and `read_data` are all 0 after reset.
  - Read of 0x30 returns the prior contents.

Source files
------------

// File: rtl/memory_responder_if.sv
// memory_responder_if: request/response bus between the control unit and the RAM responder
interface memory_responder_if;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  byte_mask;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;
  logic        error;
  modport master (
    output memory_read, memory_write, address, write_data, byte_mask,
    input  read_data, ready, busy, error
  );
  modport slave (
    input  memory_read, memory_write, address, write_data, byte_mask,
    output read_data, ready, busy, error
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: word RAM slave with programmable wait states and a one-cycle ready/error completion
module memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic rst_n,
  memory_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t state;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx, in_idx;
  logic [31:0] wdata;
  logic [3:0] cnt, mask;
  logic op_wr, rej, in_rej;
  assign in_idx = bus.address[ADDR_WIDTH+1:2];
  assign in_rej = (bus.memory_read & bus.memory_write) | (bus.address[1:0] != 2'b00);
  // a reset edge during RESP suppresses the commit, so an interrupted write never lands
  always_ff @(posedge clk)
    if (rst_n && state == RESP && op_wr && !rej)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      wdata         <= '0;
      mask          <= '0;
      op_wr         <= 1'b0;
      rej           <= 1'b0;
      bus.read_data <= '0;
      bus.ready     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        IDLE: if (bus.memory_read | bus.memory_write) begin
          op_wr    <= bus.memory_write & ~bus.memory_read;
          rej      <= in_rej;
          idx      <= in_idx;
          wdata    <= bus.write_data;
          mask     <= bus.byte_mask;
          cnt      <= LAT;
          bus.busy <= 1'b1;
          if (LAT == 4'd0) begin
            state     <= RESP;
            bus.ready <= 1'b1;
            bus.error <= in_rej;
            if (!in_rej && !bus.memory_write) bus.read_data <= mem[in_idx];
          end else state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            bus.ready <= 1'b1;
            bus.error <= rej;
            if (!rej && !op_wr) bus.read_data <= mem[idx];
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: scoreboard bench driving a LATENCY=2 and a LATENCY=0 responder against a word-array model
module tb_memory_responder;
  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [1:0] rd_d = '0, wr_d = '0;
  logic [1:0][31:0] a_d = '0, d_d = '0;
  logic [1:0][3:0] m_d = '0;
  logic [1:0] rdy, bsy, er;
  logic [1:0][31:0] rdat;
  logic [31:0] mm [2][256];
  logic [31:0] prev [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : gd
    memory_responder_if b();
    assign b.memory_read  = rd_d[g];
    assign b.memory_write = wr_d[g];
    assign b.address      = a_d[g];
    assign b.write_data   = d_d[g];
    assign b.byte_mask    = m_d[g];
    assign rdy[g]  = b.ready;
    assign bsy[g]  = b.busy;
    assign er[g]   = b.error;
    assign rdat[g] = b.read_data;
    memory_responder #(.ADDR_WIDTH(8), .LATENCY(g == 0 ? 2 : 0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n)
      for (int g = 0; g < 2; g++)
        if (rdy[g]) begin
          if (q.size() == 0 || q[0].dut != g) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready dut%0d at cycle %0d", g, cyc);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("ready_cycle", cyc, e.cyc);
            chk("error", {31'd0, er[g]}, {31'd0, e.err});
            chk("read_data", rdat[g], e.data);
            chk("busy_at_ready", {31'd0, bsy[g]}, 32'd1);
          end
        end
  // n > 1 holds the request so it is re-accepted back-to-back
  task automatic req(input int g, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input int n = 1);
    int lat, seen, idx;
    bit rej;
    lat = (g == 0) ? 2 : 0;
    rej = (r && w) || (a[1:0] != 2'b00);
    idx = int'(a[9:2]);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (!rej) begin
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (m[i]) mm[g][idx][8*i +: 8] = d[8*i +: 8];
        end else prev[g] = mm[g][idx];
      end
      q.push_back('{dut: g, cyc: cyc + 1 + lat + k * (lat + 2), data: prev[g], err: rej});
    end
    rd_d[g] = r; wr_d[g] = w; a_d[g] = a; d_d[g] = d; m_d[g] = m;
    seen = 0;
    for (int k = 0; k < 30 * n && seen < n; k++) begin
      @(negedge clk);
      if (rdy[g]) seen++;
    end
    rd_d[g] = 1'b0; wr_d[g] = 1'b0;
    chk("ready_count", seen, n);
    @(negedge clk);
    chk("busy_fall", {31'd0, bsy[g]}, 32'd0);
  endtask
  task automatic rnd_ops(input int g, input int cnt);
    logic [31:0] a;
    bit r, w;
    for (int k = 0; k < cnt; k++) begin
      a = 32'h40 + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 1) == 1;
      w = !r || ($urandom_range(0, 7) == 0);
      req(g, r, w, a, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask
  initial begin
    prev[0] = '0;
    prev[1] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_busy", {31'd0, bsy[g]}, 32'd0);
      chk("reset_ready", {31'd0, rdy[g]}, 32'd0);
      chk("reset_error", {31'd0, er[g]}, 32'd0);
      chk("reset_read_data", rdat[g], 32'd0);
    end
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int w = 0; w < 8; w++) req(g, 0, 1, 32'h40 + 4 * w, $urandom, 4'hF);
    req(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    req(0, 1, 0, 32'h10, 32'h0, 4'h0);
    req(0, 0, 1, 32'h20, 32'h11223344, 4'hF);
    req(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
    req(0, 1, 0, 32'h20, 32'h0, 4'h0);
    req(0, 1, 0, 32'h13, 32'h0, 4'h0);
    req(0, 1, 1, 32'h10, 32'h0, 4'hF);
    req(0, 1, 0, 32'h10, 32'h0, 4'h0);
    req(0, 0, 1, 32'h400, 32'h5, 4'hF);
    req(0, 1, 0, 32'h0, 32'h0, 4'h0);
    rnd_ops(0, 40);
    req(1, 1, 0, 32'h44, 32'h0, 4'h0);
    req(1, 1, 0, 32'h48, 32'h0, 4'h0, 2);
    req(1, 0, 1, 32'h4C, 32'h0BADF00D, 4'b1100);
    req(1, 1, 0, 32'h4C, 32'h0, 4'h0);
    rnd_ops(1, 30);
    req(0, 0, 1, 32'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    wr_d[0] = 1'b1; a_d[0] = 32'h30; d_d[0] = 32'hFFFFFFFF; m_d[0] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    wr_d[0] = 1'b0;
    prev[0] = '0;
    prev[1] = '0;
    chk("abort_busy", {31'd0, bsy[0]}, 32'd0);
    chk("abort_ready", {31'd0, rdy[0]}, 32'd0);
    chk("abort_error", {31'd0, er[0]}, 32'd0);
    chk("abort_read_data", rdat[0], 32'd0);
    rst_n = 1'b1;
    req(0, 1, 0, 32'h30, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
